// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: next-PC select codes,
// datapath width and the bubble encoding.
package mips_pipe_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_BR  = 3'd1,
        PCSRC_J   = 3'd2,
        PCSRC_JR  = 3'd3,
        PCSRC_EXC = 3'd4
    } pcsrc_e;

    // sll $0,$0,0 -- decode treats a bubble as an ordinary no-op
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: imem_addr is offered every cycle; imem_rdata is consumed only in a
// cycle where imem_ready=1, otherwise the fetch is retried at the same address.
interface if_fetch_stage_if;
    import mips_pipe_pkg::*;

    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;

    modport master (output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold has priority over bubble, bubble over load.
// fetch_count counts words actually accepted into IF/ID.
module if_id_reg
    import mips_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              bubble,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic [DATA_W-1:0] IF_ID_PCplus4,
    output logic              IF_ID_valid,
    output logic [DATA_W-1:0] fetch_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_instr   <= NOP_INSTR;
            IF_ID_PCplus4 <= '0;
            IF_ID_valid   <= 1'b0;
            fetch_count   <= '0;
        end else if (load_en) begin
            if (bubble) begin
                IF_ID_instr   <= NOP_INSTR;
                IF_ID_PCplus4 <= '0;
                IF_ID_valid   <= 1'b0;
            end else begin
                IF_ID_instr   <= instr;
                IF_ID_PCplus4 <= pc_plus4;
                IF_ID_valid   <= 1'b1;
                fetch_count   <= fetch_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection with a one-deep
// pending-redirect slot for redirects that arrive during a PC stall.
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h8000_0004
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PCWrite,
    input  logic                IF_Flush,
    input  logic                IF_IDWrite,
    input  logic [2:0]          PCSrc,
    input  logic [DATA_W-1:0]   BranchTarget,
    input  logic [DATA_W-1:0]   JumpTarget,
    input  logic [DATA_W-1:0]   JrTarget,
    if_fetch_stage_if.master    imem,
    output logic [DATA_W-1:0]   pc,
    output logic [DATA_W-1:0]   IF_ID_instr,
    output logic [DATA_W-1:0]   IF_ID_PCplus4,
    output logic                IF_ID_valid,
    output logic [DATA_W-1:0]   fetch_count,
    output logic                redir_pend
);

    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] redir_tgt;
    logic [DATA_W-1:0] target;
    logic              redir;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;

    // Codes 5-7 fall into the default arm and behave as sequential fetch
    always_comb begin
        redir  = 1'b1;
        target = pc_plus4;
        case (pcsrc_e'(PCSrc))
            PCSRC_BR:  target = BranchTarget;
            PCSRC_J:   target = JumpTarget;
            PCSRC_JR:  target = JrTarget;
            PCSRC_EXC: target = EXC_VECTOR;
            default:   redir  = 1'b0;
        endcase
    end

    // A pending redirect is older than any redirect arriving now, so it wins
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
        end else if (redir_pend && PCWrite) begin
            pc         <= redir_tgt;
            redir_pend <= 1'b0;
        end else if (redir && PCWrite) begin
            pc <= target;
        end else if (redir && !PCWrite && !redir_pend) begin
            redir_tgt  <= target;
            redir_pend <= 1'b1;
        end else if (PCWrite && imem.imem_ready) begin
            pc <= pc_plus4;
        end
    end

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .load_en       (IF_IDWrite),
        .bubble        (!IF_Flush || redir_pend || !imem.imem_ready),
        .instr         (imem.imem_rdata),
        .pc_plus4      (pc_plus4),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_PCplus4 (IF_ID_PCplus4),
        .IF_ID_valid   (IF_ID_valid),
        .fetch_count   (fetch_count)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of PC and IF/ID behaviour.
module tb_if_fetch_stage;
    import mips_pipe_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pc_write, if_flush, if_id_write, ready;
    logic [2:0]  pc_src;
    logic [31:0] br_t, j_t, jr_t;
    logic        use_fixed;
    logic [31:0] fixed_word, salt;

    logic [31:0] pc, IF_ID_instr, IF_ID_PCplus4, fetch_count;
    logic        IF_ID_valid, redir_pend;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc, m_tgt, m_instr, m_pc4, m_cnt;
    logic        m_pend, m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] rdata_at(input logic [31:0] a);
        return use_fixed ? fixed_word : mem_word(a);
    endfunction

    if_fetch_stage_if imem ();
    assign imem.imem_rdata = rdata_at(imem.imem_addr);
    assign imem.imem_ready = ready;

    if_fetch_stage #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (pc_write),
        .IF_Flush      (if_flush),
        .IF_IDWrite    (if_id_write),
        .PCSrc         (pc_src),
        .BranchTarget  (br_t),
        .JumpTarget    (j_t),
        .JrTarget      (jr_t),
        .imem          (imem.master),
        .pc            (pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_PCplus4 (IF_ID_PCplus4),
        .IF_ID_valid   (IF_ID_valid),
        .fetch_count   (fetch_count),
        .redir_pend    (redir_pend)
    );

    // driver tasks
    task automatic idle();
        reset = 1'b0; pc_write = 1'b1; if_flush = 1'b1; if_id_write = 1'b1;
        pc_src = 3'd0; ready = 1'b1;
    endtask

    // Advance the model by one clock using the currently driven inputs,
    // then clock the DUT and settle away from the edge.
    task automatic step();
        logic [31:0] tgt, rd;
        logic        is_redir;
        if (reset) begin
            m_pc = RESET_PC; m_pend = 1'b0; m_tgt = '0;
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = '0;
        end else begin
            rd = rdata_at(m_pc);
            is_redir = (pc_src >= 3'd1) && (pc_src <= 3'd4);
            case (pc_src)
                3'd1:    tgt = br_t;
                3'd2:    tgt = j_t;
                3'd3:    tgt = jr_t;
                3'd4:    tgt = EXC_VECTOR;
                default: tgt = m_pc + 32'd4;
            endcase
            if (if_id_write) begin
                if (!if_flush || m_pend || !ready) begin
                    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                end else begin
                    m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
                end
            end
            if (m_pend && pc_write) begin
                m_pc = m_tgt; m_pend = 1'b0;
            end else if (is_redir && pc_write) begin
                m_pc = tgt;
            end else if (is_redir && !m_pend) begin
                m_tgt = tgt; m_pend = 1'b1;
            end else if (pc_write && ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_write = 1'b1; if_flush = 1'b1; if_id_write = 1'b1;
        pc_src = 3'd4; ready = 1'b1; br_t = 32'h1234; j_t = 32'h5678; jr_t = 32'h9abc;
        step(); step();
        checks++;
        if ({pc, IF_ID_instr, IF_ID_PCplus4, IF_ID_valid, fetch_count, redir_pend} !==
            {RESET_PC, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: pc=%h instr=%h pc4=%h valid=%b cnt=%0d pend=%b (expected all zero)",
                     pc, IF_ID_instr, IF_ID_PCplus4, IF_ID_valid, fetch_count, redir_pend);
        end
    endtask

    task automatic test_sequential();
        use_fixed = 1'b1; fixed_word = 32'h2008_0001;
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (pc !== 32'(4 * i) || IF_ID_PCplus4 !== 32'(4 * i) || IF_ID_valid !== 1'b1 ||
                IF_ID_instr !== 32'h2008_0001) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: pc=%h pc4=%h valid=%b instr=%h expected pc=pc4=%h valid=1 instr=20080001",
                         i, pc, IF_ID_PCplus4, IF_ID_valid, IF_ID_instr, 4 * i);
            end
        end
        checks++;
        if (fetch_count !== 32'd4) begin
            failures++;
            $display("FAIL seq_count: fetch_count=%0d expected 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        pc_write = 1'b0; if_id_write = 1'b0; pc_src = 3'(1 + $urandom_range(0, 0));
        br_t = 32'h0000_0abc;
        pc_src = 3'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pc !== 32'h10 || IF_ID_instr !== 32'h2008_0001 || IF_ID_PCplus4 !== 32'h10 ||
                fetch_count !== 32'd4) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h pc4=%h cnt=%0d expected pc=10 instr=20080001 pc4=10 cnt=4",
                         i, pc, IF_ID_instr, IF_ID_PCplus4, fetch_count);
            end
        end
        idle();
        step();
        checks++;
        if (pc !== 32'h14 || fetch_count !== 32'd5 || IF_ID_PCplus4 !== 32'h14) begin
            failures++;
            $display("FAIL stall_resume: pc=%h cnt=%0d pc4=%h expected pc=14 cnt=5 pc4=14",
                     pc, fetch_count, IF_ID_PCplus4);
        end
    endtask

    task automatic test_branch();
        use_fixed = 1'b0;
        idle();
        repeat (3) step();
        pc_src = 3'd1; br_t = 32'h40; if_flush = 1'b0;
        step();
        checks++;
        if (pc !== 32'h40 || IF_ID_instr !== 32'h0 || IF_ID_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_flush: pc=%h instr=%h valid=%b expected pc=40 instr=0 valid=0",
                     pc, IF_ID_instr, IF_ID_valid);
        end
        idle();
        step();
        checks++;
        if (pc !== 32'h44 || IF_ID_valid !== 1'b1 || IF_ID_PCplus4 !== 32'h44 ||
            IF_ID_instr !== mem_word(32'h40)) begin
            failures++;
            $display("FAIL branch_target_fetch: pc=%h valid=%b pc4=%h instr=%h expected pc=44 valid=1 pc4=44 instr=%h",
                     pc, IF_ID_valid, IF_ID_PCplus4, IF_ID_instr, mem_word(32'h40));
        end
    endtask

    task automatic test_pending_redirect();
        idle();
        pc_src = 3'd3; jr_t = 32'h100; pc_write = 1'b0;
        step();
        pc_src = 3'd2; j_t = 32'h200;
        step();
        checks++;
        if (pc !== 32'h44 || redir_pend !== 1'b1 || IF_ID_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_hold: pc=%h pend=%b valid=%b expected pc=44 pend=1 valid=0",
                     pc, redir_pend, IF_ID_valid);
        end
        pc_write = 1'b1;
        step();
        checks++;
        if (pc !== 32'h100 || redir_pend !== 1'b0 || IF_ID_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_older_wins: pc=%h pend=%b valid=%b expected pc=100 pend=0 valid=0",
                     pc, redir_pend, IF_ID_valid);
        end
    endtask

    task automatic test_imem_wait();
        idle();
        pc_src = 3'd1; br_t = 32'h30; if_flush = 1'b0;
        step();
        idle();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'h30 || IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0) begin
                failures++;
                $display("FAIL imem_wait[%0d]: pc=%h valid=%b instr=%h expected pc=30 valid=0 instr=0",
                         i, pc, IF_ID_valid, IF_ID_instr);
            end
        end
        ready = 1'b1;
        step();
        checks++;
        if (pc !== 32'h34 || IF_ID_valid !== 1'b1 || IF_ID_PCplus4 !== 32'h34 ||
            IF_ID_instr !== mem_word(32'h30)) begin
            failures++;
            $display("FAIL imem_resume: pc=%h valid=%b pc4=%h instr=%h expected pc=34 valid=1 pc4=34 instr=%h",
                     pc, IF_ID_valid, IF_ID_PCplus4, IF_ID_instr, mem_word(32'h30));
        end
    endtask

    task automatic test_wrap_and_exception();
        idle();
        pc_src = 3'd1; br_t = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        checks++;
        if (pc !== 32'h0 || IF_ID_PCplus4 !== 32'h0 || IF_ID_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h pc4=%h valid=%b expected pc=0 pc4=0 valid=1",
                     pc, IF_ID_PCplus4, IF_ID_valid);
        end
        pc_src = 3'd4;
        step();
        checks++;
        if (pc !== EXC_VECTOR) begin
            failures++;
            $display("FAIL exc_vector: pc=%h expected %h", pc, EXC_VECTOR);
        end
        pc_src = 3'd6; br_t = 32'h0bad_0000;
        step();
        checks++;
        if (pc !== EXC_VECTOR + 32'd4) begin
            failures++;
            $display("FAIL pcsrc_reserved: pc=%h expected %h", pc, EXC_VECTOR + 32'd4);
        end
    endtask

    task automatic test_reset_while_pending();
        idle();
        pc_src = 3'd1; br_t = 32'h88;
        step();
        idle();
        pc_src = 3'd3; jr_t = 32'h300; pc_write = 1'b0;
        step();
        checks++;
        if (pc !== 32'h88 || redir_pend !== 1'b1) begin
            failures++;
            $display("FAIL pend_setup: pc=%h pend=%b expected pc=88 pend=1", pc, redir_pend);
        end
        reset = 1'b1;
        step();
        checks++;
        if (pc !== RESET_PC || redir_pend !== 1'b0 || IF_ID_valid !== 1'b0 || fetch_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_pending: pc=%h pend=%b valid=%b cnt=%0d expected pc=%h pend=0 valid=0 cnt=0",
                     pc, redir_pend, IF_ID_valid, fetch_count, RESET_PC);
        end
        idle();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            pc_write    = ($urandom_range(0, 3) != 0);
            if_flush    = ($urandom_range(0, 4) != 0);
            if_id_write = ($urandom_range(0, 4) != 0);
            ready       = ($urandom_range(0, 3) != 0);
            pc_src      = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            br_t  = {$urandom_range(0, 16'hffff), 16'h0} | 32'($urandom_range(0, 255) << 2);
            j_t   = $urandom & 32'hffff_fffc;
            jr_t  = $urandom;
            step();
            checks++;
            if ({pc, IF_ID_instr, IF_ID_PCplus4, IF_ID_valid, fetch_count, redir_pend} !==
                {m_pc, m_instr, m_pc4, m_valid, m_cnt, m_pend}) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: pc=%h/%h instr=%h/%h pc4=%h/%h valid=%b/%b cnt=%0d/%0d pend=%b/%b (got/expected)",
                             i, pc, m_pc, IF_ID_instr, m_instr, IF_ID_PCplus4, m_pc4,
                             IF_ID_valid, m_valid, fetch_count, m_cnt, redir_pend, m_pend);
            end
        end
    endtask

    initial begin
        salt = $urandom;
        use_fixed = 1'b0;
        fixed_word = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_pending_redirect();
        test_imem_wait();
        test_wrap_and_exception();
        test_reset_while_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
